// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional JAL prediction is enabled by defining FETCH_JAL_PREDICT_EN.
package fetch_pkg;

  localparam logic [6:0]  OPC_JAL      = 7'b1101111;
  localparam logic [31:0] RESET_PC_DEF = 32'h0001_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] insn;
    logic        error;
    logic        taken;
  } entry_t;

  // Takes J-immediate bits [20:2] in order and returns the signed word offset.
  function automatic logic signed [29:0] jal_word_off(input logic signed [18:0] imm_w);
    return 30'(imm_w);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Handshake bundle between fetch, the icache, the ROB redirect path and decode.
interface fetch_if;
  logic        fetch_ic_req;
  logic [31:2] fetch_ic_addr;
  logic        fetch_ic_flush;
  logic        icache_ready;
  logic        icache_valid;
  logic        icache_error;
  logic [31:0] icache_data;
  logic        rob_flush;
  logic [31:2] rob_flush_pc;
  logic        decode_ready;
  logic        fetch_de_valid;
  logic [31:2] fetch_de_addr;
  logic [31:0] fetch_de_insn;
  logic        fetch_de_error;
  logic        fetch_de_taken;

  modport master (
    output fetch_ic_req, fetch_ic_addr, fetch_ic_flush,
    input  icache_ready, icache_valid, icache_error, icache_data,
    input  rob_flush, rob_flush_pc, decode_ready,
    output fetch_de_valid, fetch_de_addr, fetch_de_insn, fetch_de_error, fetch_de_taken
  );

  modport slave (
    input  fetch_ic_req, fetch_ic_addr, fetch_ic_flush,
    output icache_ready, icache_valid, icache_error, icache_data,
    output rob_flush, rob_flush_pc, decode_ready,
    input  fetch_de_valid, fetch_de_addr, fetch_de_insn, fetch_de_error, fetch_de_taken
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched instruction entries with clear and occupancy count.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  assign head = mem[rptr];

  // The credit scheme upstream must make this unreachable.
  assert property (@(posedge clk) disable iff (rst || clear) !(push && !pop && count == FULL));

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC, credit-limited icache requests, response queue, redirects.
// Define FETCH_JAL_PREDICT_EN to redirect on fetched JAL instructions.
module fetch
  import fetch_pkg::*;
#(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master bus
);
  localparam int AW = $clog2(QDEPTH);

  state_t      state;
  logic [29:0] pc;
  logic        vld_p0, vld_p1;
  logic [29:0] addr_p0, addr_p1;
  logic [1:0]  inflight;
  logic [AW:0] count;
  entry_t      head, push_data;
  logic        head_valid, push, pop, issue, jal_hit, credit_ok;
  logic [29:0] jal_target;

`ifdef FETCH_JAL_PREDICT_EN
  assign jal_hit    = bus.icache_valid & ~bus.icache_error & (bus.icache_data[6:0] == OPC_JAL);
  assign jal_target = addr_p1 + jal_word_off({bus.icache_data[31], bus.icache_data[19:12],
                                              bus.icache_data[20], bus.icache_data[30:22]});
`else
  assign jal_hit    = 1'b0;
  assign jal_target = addr_p1;
`endif

  assign inflight  = {1'b0, vld_p0} + {1'b0, vld_p1};
  assign credit_ok = (int'(count) + int'(inflight)) < QDEPTH;
  assign issue     = ~rst & (state == RUN) & bus.icache_ready & ~bus.rob_flush & credit_ok & ~jal_hit;
  assign push      = bus.icache_valid & ~bus.rob_flush;
  assign head_valid = (count != '0);
  assign pop       = head_valid & bus.decode_ready;

  assign push_data = '{addr: addr_p1, insn: bus.icache_data, error: bus.icache_error, taken: jal_hit};

  assign bus.fetch_ic_req   = issue;
  assign bus.fetch_ic_addr  = pc;
  assign bus.fetch_ic_flush = ~rst & (bus.rob_flush | jal_hit);

  // Control: FSM, PC and in-flight valids
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      pc     <= RESET_PC[31:2];
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (bus.rob_flush) begin
      state  <= RUN;
      pc     <= bus.rob_flush_pc;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= issue;
      vld_p1 <= vld_p0;
      if (jal_hit) begin
        pc     <= jal_target;
        vld_p0 <= 1'b0;
        vld_p1 <= 1'b0;
      end else if (issue) begin
        pc <= pc + 30'd1;
      end
      if (bus.icache_valid && bus.icache_error) state <= HALT;
    end
  end

  // In-flight address stages p0 -> p1, aligned with the 2-cycle response
  always_ff @(posedge clk) begin
    addr_p0 <= pc;
    addr_p1 <= addr_p0;
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.rob_flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign bus.fetch_de_valid = head_valid;
  assign bus.fetch_de_addr  = head_valid ? head.addr  : '0;
  assign bus.fetch_de_insn  = head_valid ? head.insn  : '0;
  assign bus.fetch_de_error = head_valid & head.error;
  assign bus.fetch_de_taken = head_valid & head.taken;

endmodule

// File: tb/tb_fetch.sv
// Randomised bench for fetch: icache responder, queue-based reference model, directed scenarios.
module tb_fetch;
  import fetch_pkg::*;

  localparam int          QDEPTH = 4;
  localparam logic [31:0] RPC    = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch #(.QDEPTH(QDEPTH), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: outstanding request addresses and queued entries
  entry_t      mq[$];
  logic [29:0] mfl[$];
  logic [29:0] mpc;
  bit          mhalt;
  bit          rst_edge;

  // icache responder
  logic        ic_v0, ic_v1, ic_e0, ic_e1;
  logic [29:0] ic_a0, ic_a1;
  logic [31:0] ic_d0, ic_d1;
  bit          rand_mode, err_en, jal_en;
  logic [29:0] err_word, jal_word;
  logic [31:0] jal_insn;

  // scenario observation flags
  bit          saw_err, jal_pulse, jal_pending, taken_seen, skip_seen;
  logic [29:0] jal_next;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_jal(input logic [31:0] insn, input logic err);
`ifdef FETCH_JAL_PREDICT_EN
    return !err && insn[6:0] == 7'h6F;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [29:0] model_target(input logic [29:0] a, input logic [31:0] insn);
    logic [20:0] j;
    int          imm;
    logic [31:0] b;
    j   = {insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    imm = $signed(j);
    b   = {a, 2'b00} + 32'(imm);
    return b[31:2];
  endfunction

  function automatic logic [31:0] gen_data(input logic [29:0] a);
    if (jal_en && a == jal_word) return jal_insn;
    if (rand_mode) return $urandom;
    return {a, 2'b00};
  endfunction

  task automatic cycle();
    logic        c_rst, c_flush, c_dr, c_iv, c_ie, c_rdy, a_req, a_flush, e_req, jal;
    logic [29:0] c_fpc, a_addr, fa;
    logic [31:0] c_id;
    @(negedge clk);
    c_rst = rst; c_flush = bus.rob_flush; c_fpc = bus.rob_flush_pc; c_dr = bus.decode_ready;
    c_iv = bus.icache_valid; c_ie = bus.icache_error; c_id = bus.icache_data; c_rdy = bus.icache_ready;
    a_req = bus.fetch_ic_req; a_flush = bus.fetch_ic_flush; a_addr = bus.fetch_ic_addr;
    jal   = c_iv && model_jal(c_id, c_ie);
    e_req = !mhalt && c_rdy && !c_flush && (mq.size() + mfl.size() < QDEPTH) && !jal;
    if (c_rst) begin
      if (rst_edge) begin
        chk("rst_ic_req", a_req, 0);
        chk("rst_ic_flush", a_flush, 0);
        chk("rst_de_valid", bus.fetch_de_valid, 0);
        chk("rst_de_fields", {bus.fetch_de_addr, bus.fetch_de_insn, bus.fetch_de_error, bus.fetch_de_taken}, 0);
        chk("rst_pc", a_addr, 30'h4000);
      end
    end else begin
      chk("ic_req", a_req, e_req);
      chk("ic_addr", a_addr, mpc);
      chk("ic_flush", a_flush, c_flush || jal);
      chk("de_valid", bus.fetch_de_valid, mq.size() > 0);
      if (mq.size() > 0)
        chk("de_head", {bus.fetch_de_addr, bus.fetch_de_insn, bus.fetch_de_error, bus.fetch_de_taken},
            {mq[0].addr, mq[0].insn, mq[0].error, mq[0].taken});
      else
        chk("de_idle", {bus.fetch_de_addr, bus.fetch_de_insn, bus.fetch_de_error, bus.fetch_de_taken}, 0);
      if (bus.fetch_de_valid && bus.fetch_de_error && err_en && bus.fetch_de_addr == err_word) saw_err = 1;
      if (jal_pending && a_req) begin jal_next = a_addr; jal_pending = 0; end
      if (jal_en && bus.fetch_de_valid && bus.fetch_de_addr == jal_word && bus.fetch_de_taken) taken_seen = 1;
      if (jal_en && bus.fetch_de_valid && bus.fetch_de_addr == jal_word + 30'd1) skip_seen = 1;
    end
    @(posedge clk);
    rst_edge = c_rst;
    if (c_rst) begin
      mq.delete(); mfl.delete(); mpc = RPC[31:2]; mhalt = 0;
    end else if (c_flush) begin
      mq.delete(); mfl.delete(); mpc = c_fpc; mhalt = 0;
    end else begin
      if (mq.size() > 0 && c_dr) void'(mq.pop_front());
      if (c_iv) begin
        fa = (mfl.size() > 0) ? mfl.pop_front() : 30'd0;
        mq.push_back('{addr: fa, insn: c_id, error: c_ie, taken: jal});
        if (c_ie) mhalt = 1;
        if (jal) begin
          mpc = model_target(fa, c_id);
          mfl.delete();
          jal_pulse = 1;
          jal_pending = 1;
        end
      end
      if (e_req) begin
        mfl.push_back(mpc);
        mpc = mpc + 30'd1;
      end
    end
    if (c_rst || a_flush) begin
      ic_v0 = 0; ic_v1 = 0;
    end else begin
      ic_v1 = ic_v0; ic_a1 = ic_a0; ic_d1 = ic_d0; ic_e1 = ic_e0;
      ic_v0 = a_req; ic_a0 = a_addr; ic_d0 = gen_data(a_addr);
      ic_e0 = (err_en && a_addr == err_word) || (rand_mode && $urandom_range(0, 47) == 0);
    end
    #1;
    bus.icache_valid = ic_v1;
    bus.icache_data  = ic_v1 ? ic_d1 : $urandom;
    bus.icache_error = ic_v1 & ic_e1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic redirect(input logic [29:0] target);
    bus.rob_flush = 1; bus.rob_flush_pc = target;
    cycle();
    bus.rob_flush = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.icache_ready = 0; bus.decode_ready = 0; bus.rob_flush = 0; bus.rob_flush_pc = '0;
    bus.icache_valid = 0; bus.icache_error = 0; bus.icache_data = '0;
    mpc = RPC[31:2]; mhalt = 0; rst_edge = 0;
    ic_v0 = 0; ic_v1 = 0; ic_e0 = 0; ic_e1 = 0; ic_a0 = '0; ic_a1 = '0; ic_d0 = '0; ic_d1 = '0;
    rand_mode = 0; err_en = 0; jal_en = 0; err_word = '0; jal_word = '0; jal_insn = '0;
    saw_err = 0; jal_pulse = 0; jal_pending = 0; taken_seen = 0; skip_seen = 0; jal_next = '0;

    rst = 1; run(3); rst = 0;

    // back-to-back streaming, data = byte address
    bus.icache_ready = 1; bus.decode_ready = 1; #1;
    chk("t1_first_req", bus.fetch_ic_req, 1);
    chk("t1_first_addr", bus.fetch_ic_addr, 30'h4000);
    run(2); #1;
    chk("t1_not_early", bus.fetch_de_valid, 0);
    cycle(); #1;
    chk("t1_insn0", {bus.fetch_de_valid, bus.fetch_de_insn}, {1'b1, 32'h0001_0000});
    cycle(); #1;
    chk("t1_insn1", bus.fetch_de_insn, 32'h0001_0004);
    cycle(); #1;
    chk("t1_insn2", bus.fetch_de_insn, 32'h0001_0008);
    run(4);

    // decode stall fills the queue, then requests stop
    bus.decode_ready = 0; run(12); #1;
    chk("t2_stall_req", bus.fetch_ic_req, 0);
    bus.decode_ready = 1; #1;
    chk("t2_full_noreq", bus.fetch_ic_req, 0);
    cycle(); #1;
    chk("t2_resume", bus.fetch_ic_req, 1);
    run(5);

    // redirect to 0x2000 with two requests in flight
    bus.rob_flush = 1; bus.rob_flush_pc = 30'h800; #1;
    chk("t3_flush_pulse", bus.fetch_ic_flush, 1);
    chk("t3_no_issue", bus.fetch_ic_req, 0);
    cycle(); bus.rob_flush = 0; #1;
    chk("t3_q_empty", bus.fetch_de_valid, 0);
    chk("t3_next_req", {bus.fetch_ic_req, bus.fetch_ic_addr}, {1'b1, 30'h800});
    run(2); #1;
    chk("t3_not_early", bus.fetch_de_valid, 0);
    cycle(); #1;
    chk("t3_first_de", {bus.fetch_de_valid, bus.fetch_de_addr}, {1'b1, 30'h800});
    run(3);

    // fetch fault on 0x1000C halts issue
    err_en = 1; err_word = 30'h4003;
    redirect(30'h4000); run(14); #1;
    chk("t4_err_seen", saw_err, 1);
    chk("t4_halt_req", bus.fetch_ic_req, 0);
    err_en = 0;

`ifdef FETCH_JAL_PREDICT_EN
    // JAL at 0x10004 jumping +0x100
    jal_en = 1; jal_word = 30'h4001; jal_insn = 32'h1000_006F;
    jal_pulse = 0; jal_pending = 0;
    redirect(30'h4000); run(10);
    chk("t5_flush_pulse", jal_pulse, 1);
    chk("t5_next_req", jal_next, 30'h4041);
    chk("t5_taken", taken_seen, 1);
    chk("t5_skip", skip_seen, 0);
    jal_en = 0;
`endif

    // redirect coincident with a response and a pop
    redirect(30'h4000); run(6);
    redirect(30'h900); #1;
    chk("t6_q_empty", bus.fetch_de_valid, 0);
    chk("t6_pc", bus.fetch_ic_addr, 30'h900);
    run(4);

    // randomised traffic
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      bus.icache_ready = ($urandom_range(0, 3) != 0);
      bus.decode_ready = ($urandom_range(0, 2) != 0);
      bus.rob_flush    = ($urandom_range(0, 39) == 0);
      bus.rob_flush_pc = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
      rst = (i == 1500 || i == 1501);
      cycle();
    end
    rst = 0; bus.rob_flush = 0;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
